// File: rtl/dma_pkg.sv
// Shared definitions for the DMA bus-side transfer engine.
package dma_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BUS_AW  = 32;

  localparam int unsigned STATUS_BUSY  = 0;
  localparam int unsigned STATUS_ERROR = 1;
  localparam int unsigned STATUS_W     = 2;

  localparam logic [1:0] DIR_BUS2MEM = 2'b01;
  localparam logic [1:0] DIR_MEM2BUS = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_BEGIN     = 3'd2,
    ST_READ      = 3'd3,
    ST_WRITE     = 3'd4,
    ST_END_WRITE = 3'd5,
    ST_GAP       = 3'd6
  } state_t;

endpackage

// File: rtl/dma_word_holder.sv
// One-entry skid register: keeps the word on the bus stable while the slave stalls,
// since the scratchpad address has already moved on to the next word.
module dma_word_holder
  import dma_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic [WORD_W-1:0] mem_read_data,
  output logic [WORD_W-1:0] word_c
);

  logic              held_q;
  logic [WORD_W-1:0] data_q;

  // Capture the presented word on the first stall cycle, release on acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      held_q <= 1'b0;
      data_q <= '0;
    end else if (hold) begin
      if (!held_q) begin
        data_q <= mem_read_data;
        held_q <= 1'b1;
      end
    end else begin
      held_q <= 1'b0;
    end
  end

  assign word_c = held_q ? data_q : mem_read_data;

endmodule

// File: rtl/dma_bus_controller.sv
// Bus-side DMA engine: moves block_size words between the system bus and
// scratchpad port B in bursts of at most burst_size+1 words.
module dma_bus_controller
  import dma_pkg::*;
#(
  parameter int unsigned MEM_AW  = 9,
  parameter int unsigned BLOCK_W = 10,
  parameter int unsigned BURST_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_transfer,
  input  logic [1:0]         direction,
  input  logic [BUS_AW-1:0]  bus_start_address,
  input  logic [MEM_AW-1:0]  memory_start_address,
  input  logic [BLOCK_W-1:0] block_size,
  input  logic [BURST_W-1:0] burst_size,
  output logic               busy,
  output logic               error,
  output logic [MEM_AW-1:0]  mem_address,
  output logic               mem_write_enable,
  output logic [WORD_W-1:0]  mem_write_data,
  input  logic [WORD_W-1:0]  mem_read_data,
  output logic               request_out,
  input  logic               granted_in,
  output logic               begin_transaction_out,
  output logic [WORD_W-1:0]  address_data_out,
  output logic [3:0]         byte_enables_out,
  output logic [BURST_W-1:0] burst_size_out,
  output logic               read_n_write_out,
  output logic               data_valid_out,
  output logic               end_transaction_out,
  input  logic [WORD_W-1:0]  address_data_in,
  input  logic               data_valid_in,
  input  logic               end_transaction_in,
  input  logic               busy_in,
  input  logic               error_in
);

  localparam int unsigned REM_W  = BLOCK_W + 1;
  localparam int unsigned LEN_W  = BURST_W + 1;
  localparam int unsigned CALC_W = (REM_W > LEN_W) ? REM_W : LEN_W;

  state_t state, state_next;

  logic [1:0]          dir_q;
  logic [BUS_AW-1:0]   bus_addr_q;
  logic [MEM_AW-1:0]   mem_ptr_q;
  logic [REM_W-1:0]    remaining_q;
  logic [BURST_W-1:0]  burst_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_q;
  logic [STATUS_W-1:0] status_q;

  logic                start_ok_c;
  logic                abort_c;
  logic                word_accept_c;
  logic                hold_c;
  logic                read_beat_c;
  logic                last_beat_c;
  logic [CALC_W-1:0]   burst_words_c;
  logic [CALC_W-1:0]   rem_words_c;
  logic [LEN_W-1:0]    len_c;
  logic [REM_W-1:0]    rem_after_read_c;
  logic [WORD_W-1:0]   word_c;

  assign start_ok_c = start_transfer
                   && ((direction == DIR_BUS2MEM) || (direction == DIR_MEM2BUS))
                   && (block_size != '0);
  assign abort_c          = (state != ST_IDLE) && error_in;
  assign burst_words_c    = CALC_W'(burst_q) + CALC_W'(1);
  assign rem_words_c      = CALC_W'(remaining_q);
  assign len_c            = LEN_W'((burst_words_c < rem_words_c) ? burst_words_c : rem_words_c);
  assign word_accept_c    = (state == ST_WRITE) && !busy_in;
  assign hold_c           = (state == ST_WRITE) && busy_in;
  assign read_beat_c      = (state == ST_READ) && data_valid_in && !error_in;
  assign last_beat_c      = (beat_q == (len_q - LEN_W'(1)));
  assign rem_after_read_c = remaining_q - REM_W'(read_beat_c);

  assign busy  = status_q[STATUS_BUSY];
  assign error = status_q[STATUS_ERROR];

  dma_word_holder u_word_holder (
    .clock         (clock),
    .reset         (reset),
    .hold          (hold_c),
    .mem_read_data (mem_read_data),
    .word_c        (word_c)
  );

  // State register, latched configuration, pointers and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      dir_q       <= '0;
      bus_addr_q  <= '0;
      mem_ptr_q   <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      status_q    <= '0;
    end else begin
      state                 <= state_next;
      status_q[STATUS_BUSY] <= (state_next != ST_IDLE);
      if (abort_c) status_q[STATUS_ERROR] <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_ok_c) begin
            dir_q                  <= direction;
            bus_addr_q             <= bus_start_address;
            mem_ptr_q              <= memory_start_address;
            remaining_q            <= REM_W'(block_size);
            burst_q                <= burst_size;
            status_q[STATUS_ERROR] <= 1'b0;
          end
        end
        ST_BEGIN: begin
          len_q  <= len_c;
          beat_q <= '0;
        end
        ST_READ: begin
          if (read_beat_c) begin
            mem_ptr_q   <= mem_ptr_q + MEM_AW'(1);
            remaining_q <= rem_after_read_c;
          end
        end
        ST_WRITE: begin
          if (word_accept_c) begin
            mem_ptr_q   <= mem_ptr_q + MEM_AW'(1);
            remaining_q <= remaining_q - REM_W'(1);
            beat_q      <= beat_q + LEN_W'(1);
          end
        end
        ST_GAP: bus_addr_q <= bus_addr_q + (BUS_AW'(len_q) << 2);
        default: ;
      endcase
    end
  end

  // Next-state and bus/scratchpad output decode.
  always_comb begin
    state_next            = state;
    request_out           = 1'b0;
    begin_transaction_out = 1'b0;
    address_data_out      = '0;
    byte_enables_out      = '0;
    burst_size_out        = '0;
    read_n_write_out      = 1'b0;
    data_valid_out        = 1'b0;
    end_transaction_out   = 1'b0;
    mem_address           = '0;
    mem_write_enable      = 1'b0;
    mem_write_data        = '0;
    case (state)
      ST_IDLE: begin
        if (start_ok_c) state_next = ST_REQUEST;
      end
      ST_REQUEST: begin
        request_out = 1'b1;
        if (granted_in) state_next = ST_BEGIN;
      end
      ST_BEGIN: begin
        request_out           = 1'b1;
        begin_transaction_out = 1'b1;
        address_data_out      = bus_addr_q;
        byte_enables_out      = 4'hF;
        burst_size_out        = BURST_W'(len_c - LEN_W'(1));
        read_n_write_out      = (dir_q == DIR_BUS2MEM);
        if (dir_q == DIR_MEM2BUS) mem_address = mem_ptr_q;
        state_next = (dir_q == DIR_BUS2MEM) ? ST_READ : ST_WRITE;
      end
      ST_READ: begin
        request_out      = 1'b1;
        mem_address      = mem_ptr_q;
        mem_write_enable = read_beat_c;
        mem_write_data   = address_data_in;
        if (end_transaction_in)
          state_next = (rem_after_read_c == '0) ? ST_IDLE : ST_GAP;
      end
      ST_WRITE: begin
        request_out      = 1'b1;
        data_valid_out   = 1'b1;
        address_data_out = word_c;
        // Prefetch the following word; a stalled word lives in the holder.
        mem_address      = mem_ptr_q + MEM_AW'(1);
        if (word_accept_c && last_beat_c) state_next = ST_END_WRITE;
      end
      ST_END_WRITE: begin
        end_transaction_out = 1'b1;
        state_next = (remaining_q == '0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: state_next = ST_REQUEST;
      default: state_next = ST_IDLE;
    endcase
    if (abort_c) state_next = ST_IDLE;
  end

endmodule

// File: tb/tb_dma_bus_controller.sv
// Directed bench for dma_bus_controller with a scratchpad model on port B.
module tb_dma_bus_controller;

  logic        clock;
  logic        reset;
  logic        start_transfer;
  logic [1:0]  direction;
  logic [31:0] bus_start_address;
  logic [8:0]  memory_start_address;
  logic [9:0]  block_size;
  logic [7:0]  burst_size;
  logic        busy;
  logic        error;
  logic [8:0]  mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        request_out;
  logic        granted_in;
  logic        begin_transaction_out;
  logic [31:0] address_data_out;
  logic [3:0]  byte_enables_out;
  logic [7:0]  burst_size_out;
  logic        read_n_write_out;
  logic        data_valid_out;
  logic        end_transaction_out;
  logic [31:0] address_data_in;
  logic        data_valid_in;
  logic        end_transaction_in;
  logic        busy_in;
  logic        error_in;

  bit   [31:0] mem [512];
  logic        pre_we;
  logic [8:0]  pre_addr;
  logic [31:0] pre_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [92:0] all_out;
  assign all_out = {busy, error, mem_address, mem_write_enable, mem_write_data,
                    request_out, begin_transaction_out, address_data_out,
                    byte_enables_out, burst_size_out, read_n_write_out,
                    data_valid_out, end_transaction_out};

  dma_bus_controller dut (
    .clock                 (clock),
    .reset                 (reset),
    .start_transfer        (start_transfer),
    .direction             (direction),
    .bus_start_address     (bus_start_address),
    .memory_start_address  (memory_start_address),
    .block_size            (block_size),
    .burst_size            (burst_size),
    .busy                  (busy),
    .error                 (error),
    .mem_address           (mem_address),
    .mem_write_enable      (mem_write_enable),
    .mem_write_data        (mem_write_data),
    .mem_read_data         (mem_read_data),
    .request_out           (request_out),
    .granted_in            (granted_in),
    .begin_transaction_out (begin_transaction_out),
    .address_data_out      (address_data_out),
    .byte_enables_out      (byte_enables_out),
    .burst_size_out        (burst_size_out),
    .read_n_write_out      (read_n_write_out),
    .data_valid_out        (data_valid_out),
    .end_transaction_out   (end_transaction_out),
    .address_data_in       (address_data_in),
    .data_valid_in         (data_valid_in),
    .end_transaction_in    (end_transaction_in),
    .busy_in               (busy_in),
    .error_in              (error_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scratchpad port B: synchronous read, write strobe; pre_* loads test data.
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write_enable) mem[mem_address] <= mem_write_data;
    mem_read_data <= mem[mem_address];
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic start_xfer(input logic [1:0] dir, input logic [31:0] bus,
                            input logic [8:0] maddr, input logic [9:0] blk,
                            input logic [7:0] bst);
    direction = dir; bus_start_address = bus; memory_start_address = maddr;
    block_size = blk; burst_size = bst; start_transfer = 1'b1;
    step();
    start_transfer = 1'b0;
  endtask

  task automatic grant();
    granted_in = 1'b1;
    step();
    granted_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    total_cnt++; if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out); else pass_cnt++;
    step(); #1;
    total_cnt++; if ({busy, request_out} !== 2'b00) $display("FAIL reset_idle: got %b want 00", {busy, request_out}); else pass_cnt++;
  endtask

  task automatic test_read_bursts();
    start_xfer(2'b01, 32'h100, 9'd0, 10'd8, 8'd3);
    #1;
    total_cnt++; if ({busy, request_out} !== 2'b11) $display("FAIL rd_start: got %b want 11", {busy, request_out}); else pass_cnt++;
    grant(); #1;
    total_cnt++; if ({begin_transaction_out, address_data_out, burst_size_out, read_n_write_out, byte_enables_out} !== {1'b1, 32'h100, 8'd3, 1'b1, 4'hF})
      $display("FAIL rd_begin1: got %b %h %h %b %h", begin_transaction_out, address_data_out, burst_size_out, read_n_write_out, byte_enables_out); else pass_cnt++;
    step();
    for (int i = 0; i < 4; i++) begin
      data_valid_in = 1'b1; address_data_in = 32'hA5A5_0000 + 32'(i); #1;
      total_cnt++; if ({mem_write_enable, mem_address, mem_write_data} !== {1'b1, 9'(i), 32'hA5A5_0000 + 32'(i)})
        $display("FAIL rd_memwr1: got %b %h %h want addr %0d", mem_write_enable, mem_address, mem_write_data, i); else pass_cnt++;
      step();
    end
    data_valid_in = 1'b0; end_transaction_in = 1'b1;
    step();
    end_transaction_in = 1'b0; #1;
    total_cnt++; if ({busy, request_out} !== 2'b10) $display("FAIL rd_gap: got %b want 10", {busy, request_out}); else pass_cnt++;
    step(); #1;
    total_cnt++; if (request_out !== 1'b1) $display("FAIL rd_rerequest: got %b want 1", request_out); else pass_cnt++;
    grant(); #1;
    total_cnt++; if ({begin_transaction_out, address_data_out, burst_size_out} !== {1'b1, 32'h110, 8'd3})
      $display("FAIL rd_begin2: got %b %h %h want 1 110 03", begin_transaction_out, address_data_out, burst_size_out); else pass_cnt++;
    step();
    for (int i = 4; i < 8; i++) begin
      data_valid_in = 1'b1; address_data_in = 32'hA5A5_0000 + 32'(i);
      step();
    end
    data_valid_in = 1'b0; end_transaction_in = 1'b1;
    step();
    end_transaction_in = 1'b0; #1;
    total_cnt++; if ({busy, error, request_out} !== 3'b000) $display("FAIL rd_done: got %b want 000", {busy, error, request_out}); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if (mem[i] !== 32'hA5A5_0000 + 32'(i)) $display("FAIL rd_mem[%0d]: got %h want %h", i, mem[i], 32'hA5A5_0000 + 32'(i)); else pass_cnt++;
    end
  endtask

  task automatic test_write_wrap();
    logic [8:0] addrs [5] = '{9'd510, 9'd511, 9'd0, 9'd1, 9'd2};
    for (int k = 0; k < 5; k++) preload(addrs[k], 32'hC0DE_0000 + 32'(k));
    start_xfer(2'b10, 32'h2000, 9'd510, 10'd5, 8'd7);
    grant(); #1;
    total_cnt++; if ({begin_transaction_out, address_data_out, burst_size_out, read_n_write_out, mem_address} !== {1'b1, 32'h2000, 8'd4, 1'b0, 9'd510})
      $display("FAIL wr_begin: got %b %h %h %b %h", begin_transaction_out, address_data_out, burst_size_out, read_n_write_out, mem_address); else pass_cnt++;
    step();
    for (int k = 0; k < 5; k++) begin
      busy_in = 1'b0; #1;
      total_cnt++; if ({data_valid_out, address_data_out} !== {1'b1, 32'hC0DE_0000 + 32'(k)})
        $display("FAIL wr_word%0d: got %b %h want 1 %h", k, data_valid_out, address_data_out, 32'hC0DE_0000 + 32'(k)); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if ({end_transaction_out, request_out, data_valid_out} !== 3'b100)
      $display("FAIL wr_end: got %b want 100", {end_transaction_out, request_out, data_valid_out}); else pass_cnt++;
    step(); #1;
    total_cnt++; if ({busy, end_transaction_out} !== 2'b00) $display("FAIL wr_done: got %b want 00", {busy, end_transaction_out}); else pass_cnt++;
  endtask

  task automatic test_write_stall();
    bit stall_tab [9] = '{0, 1, 1, 0, 1, 1, 0, 0, 0};
    int idx_tab [9]   = '{0, 1, 1, 1, 2, 2, 2, 3, 4};
    logic [31:0] rcv [$];
    for (int k = 0; k < 5; k++) preload(9'(100 + k), 32'hB000_0000 + 32'(k));
    start_xfer(2'b10, 32'h3000, 9'd100, 10'd5, 8'd7);
    grant();
    step();
    for (int c = 0; c < 9; c++) begin
      busy_in = stall_tab[c]; #1;
      total_cnt++; if ({data_valid_out, address_data_out} !== {1'b1, 32'hB000_0000 + 32'(idx_tab[c])})
        $display("FAIL stall_cycle%0d: got %b %h want 1 %h", c, data_valid_out, address_data_out, 32'hB000_0000 + 32'(idx_tab[c])); else pass_cnt++;
      if (!stall_tab[c]) rcv.push_back(address_data_out);
      step();
    end
    busy_in = 1'b0; #1;
    total_cnt++; if (end_transaction_out !== 1'b1) $display("FAIL stall_end: got %b want 1", end_transaction_out); else pass_cnt++;
    total_cnt++; if (rcv.size() !== 5) $display("FAIL stall_count: got %0d want 5", rcv.size()); else pass_cnt++;
    for (int k = 0; k < rcv.size() && k < 5; k++) begin
      total_cnt++; if (rcv[k] !== 32'hB000_0000 + 32'(k)) $display("FAIL stall_order%0d: got %h want %h", k, rcv[k], 32'hB000_0000 + 32'(k)); else pass_cnt++;
    end
    step();
  endtask

  task automatic test_error();
    start_xfer(2'b01, 32'h300, 9'd20, 10'd8, 8'd3);
    grant();
    step();
    for (int i = 0; i < 4; i++) begin
      data_valid_in = 1'b1; address_data_in = 32'hE000_0000 + 32'(i);
      step();
    end
    data_valid_in = 1'b0; end_transaction_in = 1'b1;
    step();
    end_transaction_in = 1'b0;
    step();
    grant(); #1;
    total_cnt++; if (address_data_out !== 32'h310) $display("FAIL err_begin2: got %h want 310", address_data_out); else pass_cnt++;
    step();
    data_valid_in = 1'b1; address_data_in = 32'hE000_0004;
    step();
    data_valid_in = 1'b0; error_in = 1'b1;
    step();
    error_in = 1'b0; #1;
    total_cnt++; if ({busy, error, request_out} !== 3'b010) $display("FAIL err_abort: got %b want 010", {busy, error, request_out}); else pass_cnt++;
    data_valid_in = 1'b1; address_data_in = 32'hDEAD_BEEF; #1;
    total_cnt++; if (mem_write_enable !== 1'b0) $display("FAIL err_nowrite: got %b want 0", mem_write_enable); else pass_cnt++;
    step(); step();
    data_valid_in = 1'b0; #1;
    total_cnt++; if (error !== 1'b1) $display("FAIL err_sticky: got %b want 1", error); else pass_cnt++;
    total_cnt++; if (mem[24] !== 32'hE000_0004) $display("FAIL err_mem24: got %h want e0000004", mem[24]); else pass_cnt++;
    total_cnt++; if (mem[25] !== 32'h0) $display("FAIL err_mem25: got %h want 0", mem[25]); else pass_cnt++;
    start_xfer(2'b10, 32'h40, 9'd0, 10'd1, 8'd0);
    #1;
    total_cnt++; if ({busy, error} !== 2'b10) $display("FAIL err_clear: got %b want 10", {busy, error}); else pass_cnt++;
    grant();
    step();
    busy_in = 1'b0;
    step(); step(); #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL err_recover_done: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_ignore();
    start_xfer(2'b01, 32'h600, 9'd40, 10'd0, 8'd3);
    #1;
    total_cnt++; if ({busy, request_out} !== 2'b00) $display("FAIL ign_block0: got %b want 00", {busy, request_out}); else pass_cnt++;
    start_xfer(2'b11, 32'h600, 9'd40, 10'd4, 8'd3);
    #1;
    total_cnt++; if ({busy, request_out} !== 2'b00) $display("FAIL ign_dir11: got %b want 00", {busy, request_out}); else pass_cnt++;
    start_xfer(2'b01, 32'h500, 9'd40, 10'd2, 8'd0);
    start_xfer(2'b10, 32'h900, 9'd0, 10'd9, 8'd5);
    #1;
    total_cnt++; if ({busy, request_out, begin_transaction_out} !== 3'b110) $display("FAIL ign_busy_start: got %b want 110", {busy, request_out, begin_transaction_out}); else pass_cnt++;
    grant(); #1;
    total_cnt++; if ({address_data_out, burst_size_out, read_n_write_out} !== {32'h500, 8'd0, 1'b1})
      $display("FAIL ign_cfg1: got %h %h %b want 500 00 1", address_data_out, burst_size_out, read_n_write_out); else pass_cnt++;
    step();
    data_valid_in = 1'b1; address_data_in = 32'hF000_0000;
    step();
    data_valid_in = 1'b0; end_transaction_in = 1'b1;
    step();
    end_transaction_in = 1'b0;
    step();
    grant(); #1;
    total_cnt++; if ({address_data_out, burst_size_out} !== {32'h504, 8'd0}) $display("FAIL ign_cfg2: got %h %h want 504 00", address_data_out, burst_size_out); else pass_cnt++;
    step();
    data_valid_in = 1'b1; end_transaction_in = 1'b1; address_data_in = 32'hF000_0001; #1;
    total_cnt++; if ({mem_write_enable, mem_address} !== {1'b1, 9'd41}) $display("FAIL ign_wr41: got %b %h want 1 029", mem_write_enable, mem_address); else pass_cnt++;
    step();
    data_valid_in = 1'b0; end_transaction_in = 1'b0; #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL ign_done: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if ({mem[40], mem[41]} !== {32'hF000_0000, 32'hF000_0001}) $display("FAIL ign_mem: got %h %h", mem[40], mem[41]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    start_xfer(2'b10, 32'h700, 9'd300, 10'd4, 8'd3);
    grant();
    step();
    busy_in = 1'b0;
    step();
    #1;
    total_cnt++; if (data_valid_out !== 1'b1) $display("FAIL rst_mid_active: got %b want 1", data_valid_out); else pass_cnt++;
    reset = 1'b1;
    step(); #1;
    total_cnt++; if (all_out !== '0) $display("FAIL rst_mid_outputs: got %h want 0", all_out); else pass_cnt++;
    reset = 1'b0;
    step(); #1;
    total_cnt++; if (all_out !== '0) $display("FAIL rst_mid_idle: got %h want 0", all_out); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; start_transfer = 1'b0; direction = 2'b00;
    bus_start_address = '0; memory_start_address = '0; block_size = '0; burst_size = '0;
    granted_in = 1'b0; address_data_in = '0; data_valid_in = 1'b0;
    end_transaction_in = 1'b0; busy_in = 1'b0; error_in = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_read_bursts();
    test_write_wrap();
    test_write_stall();
    test_error();
    test_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dma_bus_controller.md
# dma_bus_controller

Bus-side transfer engine of the DMA custom instruction. It consumes the configuration registers (bus start address, memory start address, block size, burst size, control) and moves `block_size` 32-bit words between the system bus and port B of the 512×32 scratchpad in bursts. It reports busy/error back into the status register. It sits directly downstream of the CI register/scratchpad block and directly upstream of the bus arbiter.

## Interface
Parameters:
- `MEM_AW`, 9: scratchpad address width (512 words).
- `BLOCK_W`, 10: block-size width in words.
- `BURST_W`, 8: burst-size field width.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start_transfer`  in  1  one-cycle pulse when control register is written.
- `direction`  in  2  control[1:0]: 01 = bus→memory, 10 = memory→bus, 00/11 = no-op.
- `bus_start_address`  in  32  word-aligned byte address.
- `memory_start_address`  in  9  first scratchpad word.
- `block_size`  in  10  total words.
- `burst_size`  in  8  words per burst minus one.
- `busy`  out  1  status[0].
- `error`  out  1  status[1], sticky until next accepted start.
- `mem_address`  out  9  scratchpad port B address.
- `mem_write_enable`  out  1  port B write strobe.
- `mem_write_data`  out  32  port B write data.
- `mem_read_data`  in  32  port B read data, valid one cycle after address.
- `request_out`  out  1  bus request to arbiter.
- `granted_in`  in  1  bus grant.
- `begin_transaction_out`  out  1  one-cycle burst start.
- `address_data_out`  out  32  address on begin, write data otherwise.
- `byte_enables_out`  out  4  always 4'hF during begin.
- `burst_size_out`  out  8  burst length minus one, valid on begin.
- `read_n_write_out`  out  1  1 = bus read.
- `data_valid_out`  out  1  write word present.
- `end_transaction_out`  out  1  master ends write burst.
- `address_data_in`  in  32  read data.
- `data_valid_in`  in  1  read word valid.
- `end_transaction_in`  in  1  slave ends read burst.
- `busy_in`  in  1  slave stall; write word not accepted.
- `error_in`  in  1  bus error.

## Operation
- States: IDLE, REQUEST, BEGIN, READ, WRITE, END_WRITE, GAP.
- IDLE: accept `start_transfer` only if `direction` ∈ {01,10} and `block_size`≠0. On accept, latch all config, set `busy`=1, clear `error`, go to REQUEST. Otherwise ignore; `busy` stays 0.
- `start_transfer` while busy is ignored; latched config is never changed mid-transfer.
- Burst length len = min(burst_size+1, remaining); remaining is (BLOCK_W+1)-bit.
- REQUEST: `request_out`=1 until `granted_in`, then BEGIN.
- BEGIN (1 cycle): drive address, `burst_size_out`=len-1, `read_n_write_out`, `byte_enables_out`=4'hF. For write direction, issue the scratchpad read of the first word.
- READ: each `data_valid_in` writes `address_data_in` into scratchpad at mem pointer in the same cycle; pointer++, remaining--. `end_transaction_in` → GAP, or IDLE if remaining=0.
- WRITE: present word with `data_valid_out`. A word is accepted iff `data_valid_out & ~busy_in`. An unaccepted word is held stable. After the last accepted word → END_WRITE.
- END_WRITE (1 cycle): `end_transaction_out`=1, `request_out`=0; then GAP or IDLE.
- GAP (1 cycle): `request_out`=0 to give the arbiter fairness, then REQUEST with bus address += 4·len.
- Mem pointer wraps modulo 512. Bus address wraps modulo 2^32.
- `error_in` in any non-IDLE state: go to IDLE next cycle, `busy`=0, `error`=1. No `end_transaction_out`, no further memory writes.
- Entering IDLE on completion: `busy`=0, `error` unchanged (0).

## Timing
- Reset: all outputs 0; state IDLE; latched config 0. Reset mid-transfer aborts with no bus termination (the arbiter shares the reset).
- `start_transfer` at cycle t → `busy` and `request_out` high at t+1.
- Grant seen at t → `begin_transaction_out` at t+1.
- Write: first `data_valid_out` in the cycle after BEGIN. The next word follows in the cycle after acceptance (zero bubbles when `busy_in`=0).
- Read: memory write is combinational from `data_valid_in`, zero added latency.
- `busy` falls the cycle after the last END_WRITE, or after the last `end_transaction_in`.

## Structure
- Shared package `dma_pkg`: state encoding, direction codes (DIR_BUS2MEM=2'b01, DIR_MEM2BUS=2'b10), status bit indices (STATUS_BUSY=0, STATUS_ERROR=1).
- Sub-module `dma_word_holder`: one-entry skid register holding the scratchpad read word under `busy_in` stalls.

## Test plan
- Read, block 8, burst 3, bus 0x100, mem 0: two 4-word bursts at 0x100 and 0x110 with one GAP cycle between; mem[0..7] = bus data; `busy` low after second `end_transaction_in`.
- Write, block 5, burst 7, mem 510: single burst, `burst_size_out`=4; data from mem 510,511,0,1,2 (wrap); `end_transaction_out` one cycle after 5th accepted word.
- Write with `busy_in` high on words 2 and 3 for 2 cycles each: data held stable; bus receives exactly 5 words in order.
- `error_in` during 2nd read burst: `busy`=0 and `error`=1 next cycle; no further mem writes. Next valid start clears `error`.
- `block_size`=0 or `direction`=11, and start during busy: no `request_out`, config unchanged.
- `reset` asserted mid-write burst: all outputs 0 the next cycle; state IDLE.
